// File: rtl/purchase_pkg.sv
// Shared definitions for the purchase request path: product codes, price table,
// coin decode and the order terminal state encoding.
package purchase_pkg;

  localparam logic [1:0] ProdApple  = 2'b00;
  localparam logic [1:0] ProdBanana = 2'b01;
  localparam logic [1:0] ProdCarrot = 2'b10;
  localparam logic [1:0] ProdDate   = 2'b11;

  localparam logic [7:0] PriceApple  = 8'd75;
  localparam logic [7:0] PriceBanana = 8'd20;
  localparam logic [7:0] PriceCarrot = 8'd30;
  localparam logic [7:0] PriceDate   = 8'd40;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StReq,
    StWait,
    StPayout
  } state_t;

  function automatic logic [7:0] product_price(input logic [1:0] prod);
    logic [7:0] price;
    unique case (prod)
      ProdApple:  price = PriceApple;
      ProdBanana: price = PriceBanana;
      ProdCarrot: price = PriceCarrot;
      default:    price = PriceDate;
    endcase
    return price;
  endfunction

  function automatic logic [7:0] coin_decode(input logic [1:0] code);
    logic [7:0] value;
    unique case (code)
      2'b00:   value = 8'd5;
      2'b01:   value = 8'd10;
      2'b10:   value = 8'd25;
      default: value = 8'd100;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_accumulator.sv
// Credit balance register: adds decoded coins, refuses coins that would overflow
// 8 bits or arrive while the FSM is busy, and clears on request.
module coin_accumulator
  import purchase_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       coin_en,
  input  logic       coin_block,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  output logic [7:0] balance,
  output logic       coin_accept,
  output logic       coin_reject
);

  logic [8:0] sum;
  logic       fits;
  logic [7:0] balance_d;
  logic       reject_d;

  always_comb begin
    sum         = {1'b0, balance} + {1'b0, coin_decode(coin_value)};
    fits        = ~sum[8];
    coin_accept = coin_valid & coin_en & fits;
    // A coin neither enabled nor blocked lost arbitration and is dropped silently.
    reject_d    = coin_valid & (coin_block | (coin_en & ~fits));
    balance_d   = balance;
    if (clear) begin
      balance_d = 8'd0;
    end else if (coin_accept) begin
      balance_d = sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      balance     <= 8'd0;
      coin_reject <= 1'b0;
    end else begin
      balance     <= balance_d;
      coin_reject <= reject_d;
    end
  end

endmodule

// File: rtl/order_terminal.sv
// Customer-side initiator for the purchase manager: collects credit, issues the
// buy request, judges the one-hot response or timeout, and pays out change.
module order_terminal
  import purchase_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_product,
  input  logic       cancel,
  input  logic       apple,
  input  logic       banana,
  input  logic       carrot,
  input  logic       date,
  input  logic       error,
  output logic       buy,
  output logic [1:0] product,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       vend_ok,
  output logic       vend_fail,
  output logic       change_valid,
  output logic [7:0] change
);

  localparam int unsigned CntW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RESP_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      product_d;
  logic [7:0]      change_d;
  logic            vend_ok_d, vend_fail_d, change_valid_d;
  logic            clear, coin_en, coin_block, coin_accept;
  logic [7:0]      balance;
  logic [3:0]      resp;
  logic            resp_any;

  coin_accumulator u_coin_accumulator (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .coin_en    (coin_en),
    .coin_block (coin_block),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .balance    (balance),
    .coin_accept(coin_accept),
    .coin_reject(coin_reject)
  );

  assign credit = balance;
  assign buy    = (state_q == StReq) | (state_q == StWait);
  assign busy   = buy;
  assign resp   = {date, carrot, banana, apple};
  assign resp_any = (|resp) | error;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    product_d      = product;
    change_d       = change;
    vend_ok_d      = 1'b0;
    vend_fail_d    = 1'b0;
    change_valid_d = 1'b0;
    clear          = 1'b0;
    coin_en        = (state_q == StIdle) | ((state_q == StCollect) & ~cancel);
    coin_block     = (state_q == StReq) | (state_q == StWait) | (state_q == StPayout);
    unique case (state_q)
      StIdle: begin
        if (coin_accept) state_d = StCollect;
      end
      StCollect: begin
        if (cancel) begin
          state_d  = StPayout;
          change_d = balance;
        end else if (!coin_valid && sel_valid) begin
          if (balance < product_price(sel_product)) begin
            vend_fail_d = 1'b1;
          end else begin
            product_d = sel_product;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (resp_any) begin
          state_d = StPayout;
          if (!error && (resp == (4'b0001 << product))) begin
            vend_ok_d = 1'b1;
            change_d  = balance - product_price(product);
          end else begin
            vend_fail_d = 1'b1;
            change_d    = balance;
          end
        end else if (cnt_q == CntLast) begin
          state_d     = StPayout;
          vend_fail_d = 1'b1;
          change_d    = balance;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPayout: begin
        state_d        = StIdle;
        change_valid_d = 1'b1;
        clear          = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      product      <= 2'b00;
      change       <= 8'd0;
      vend_ok      <= 1'b0;
      vend_fail    <= 1'b0;
      change_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      product      <= product_d;
      change       <= change_d;
      vend_ok      <= vend_ok_d;
      vend_fail    <= vend_fail_d;
      change_valid <= change_valid_d;
    end
  end

endmodule

// File: tb/tb_order_terminal.sv
// Directed bench for order_terminal: purchases, refusals, manager faults,
// timeout, credit boundaries and asynchronous reset during a request.
module tb_order_terminal;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, sel_valid, cancel;
  logic [1:0] coin_value, sel_product;
  logic       apple, banana, carrot, date, error;
  logic       buy, busy, coin_reject, vend_ok, vend_fail, change_valid;
  logic [1:0] product;
  logic [7:0] credit, change;
  logic [3:0] pulses;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  order_terminal #(.RESP_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .sel_valid   (sel_valid),
    .sel_product (sel_product),
    .cancel      (cancel),
    .apple       (apple),
    .banana      (banana),
    .carrot      (carrot),
    .date        (date),
    .error       (error),
    .buy         (buy),
    .product     (product),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .vend_ok     (vend_ok),
    .vend_fail   (vend_fail),
    .change_valid(change_valid),
    .change      (change)
  );

  assign pulses = {vend_ok, vend_fail, change_valid, coin_reject};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic insert_coin(input logic [1:0] code, input logic [7:0] exp_credit,
                             input logic exp_rej);
    coin_valid = 1'b1;
    coin_value = code;
    tick();
    coin_valid = 1'b0;
    check_eq("coin_credit", credit, exp_credit);
    check_eq("coin_reject", coin_reject, exp_rej);
  endtask

  task automatic select(input logic [1:0] p);
    sel_valid   = 1'b1;
    sel_product = p;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic expect_payout(input string tag, input logic [7:0] exp_change);
    tick();
    check_eq({tag, "_change_valid"}, change_valid, 1);
    check_eq({tag, "_change"}, change, exp_change);
    check_eq({tag, "_credit_clear"}, credit, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    {coin_valid, sel_valid, cancel, apple, banana, carrot, date, error} = '0;
    coin_value  = 2'b00;
    sel_product = 2'b00;
    repeat (3) tick();
    check_eq("rst_credit", credit, 0);
    check_eq("rst_buy", buy, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_product", product, 0);
    check_eq("rst_change", change, 0);
    check_eq("rst_pulses", pulses, 0);
    reset = 1'b1;
    tick();

    // Apple: exact credit, response two cycles after buy rises.
    insert_coin(2'b10, 8'd25, 1'b0);
    insert_coin(2'b10, 8'd50, 1'b0);
    insert_coin(2'b10, 8'd75, 1'b0);
    select(2'b00);
    check_eq("apple_buy", buy, 1);
    check_eq("apple_busy", busy, 1);
    check_eq("apple_product", product, 0);
    tick();
    tick();
    apple = 1'b1;
    tick();
    apple = 1'b0;
    check_eq("apple_vend_ok", vend_ok, 1);
    check_eq("apple_buy_fall", buy, 0);
    expect_payout("apple", 8'd0);

    // Banana: response raised during REQ must be ignored until WAIT.
    insert_coin(2'b11, 8'd100, 1'b0);
    select(2'b01);
    banana = 1'b1;
    tick();
    check_eq("banana_req_ignored", vend_ok, 0);
    check_eq("banana_buy_wait", buy, 1);
    tick();
    banana = 1'b0;
    check_eq("banana_vend_ok", vend_ok, 1);
    expect_payout("banana", 8'd80);

    // Insufficient credit for date.
    insert_coin(2'b01, 8'd10, 1'b0);
    insert_coin(2'b01, 8'd20, 1'b0);
    select(2'b11);
    check_eq("short_vend_fail", vend_fail, 1);
    check_eq("short_buy", buy, 0);
    check_eq("short_credit", credit, 20);
    tick();
    check_eq("short_buy_after", buy, 0);
    check_eq("short_fail_pulse", vend_fail, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    expect_payout("short", 8'd20);

    // Manager error, then mismatched line.
    for (int k = 0; k < 2; k++) begin
      insert_coin(2'b10, 8'd25, 1'b0);
      insert_coin(2'b01, 8'd35, 1'b0);
      insert_coin(2'b00, 8'd40, 1'b0);
      select(2'b10);
      tick();
      if (k == 0) error = 1'b1;
      else        date  = 1'b1;
      tick();
      error = 1'b0;
      date  = 1'b0;
      check_eq("fault_vend_fail", vend_fail, 1);
      check_eq("fault_vend_ok", vend_ok, 0);
      expect_payout("fault", 8'd40);
    end

    // Timeout: vend_fail nine cycles after buy rises; coin in WAIT rejected.
    insert_coin(2'b10, 8'd25, 1'b0);
    insert_coin(2'b00, 8'd30, 1'b0);
    select(2'b10);
    check_eq("to_buy", buy, 1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        coin_valid = 1'b1;
        coin_value = 2'b00;
      end
      tick();
      coin_valid = 1'b0;
      if (i == 3) begin
        check_eq("to_coin_reject", coin_reject, 1);
        check_eq("to_credit_held", credit, 30);
      end
      check_eq("to_early_fail", vend_fail, 0);
    end
    check_eq("to_product_held", product, 2);
    tick();
    check_eq("to_vend_fail", vend_fail, 1);
    check_eq("to_buy_fall", buy, 0);
    expect_payout("to", 8'd30);

    // Overflow boundary: 255 exactly accepted, beyond rejected.
    insert_coin(2'b11, 8'd100, 1'b0);
    insert_coin(2'b11, 8'd200, 1'b0);
    insert_coin(2'b11, 8'd200, 1'b1);
    tick();
    check_eq("ovf_reject_pulse", coin_reject, 0);
    insert_coin(2'b10, 8'd225, 1'b0);
    insert_coin(2'b10, 8'd250, 1'b0);
    insert_coin(2'b00, 8'd255, 1'b0);
    insert_coin(2'b00, 8'd255, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    expect_payout("max", 8'd255);

    // Cancel beats a simultaneous coin: silent drop, full refund.
    insert_coin(2'b11, 8'd100, 1'b0);
    insert_coin(2'b11, 8'd200, 1'b0);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_value = 2'b11;
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    check_eq("cancel_no_reject", coin_reject, 0);
    check_eq("cancel_credit", credit, 200);
    expect_payout("cancel", 8'd200);

    // Asynchronous reset while waiting for the manager.
    insert_coin(2'b01, 8'd10, 1'b0);
    insert_coin(2'b01, 8'd20, 1'b0);
    select(2'b01);
    tick();
    check_eq("rw_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("rw_buy", buy, 0);
    check_eq("rw_credit", credit, 0);
    check_eq("rw_busy_clr", busy, 0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rw_pulses", pulses, 0);
    check_eq("rw_idle_buy", buy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/order_terminal.md
# order_terminal

Customer-side front end for the purchase manager. It accumulates coins into a credit balance and takes a product selection. It then drives the manager's `buy`/`product`/`credit` request, waits for the manager's one-hot dispense or `error` response, and returns change or a refund. It sits between the coin/keypad inputs and the purchase manager, forming the initiator end of that request/response interface.

## Interface
- `RESP_TIMEOUT`, default 8: cycles to wait for a manager response before the purchase is failed.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `coin_valid` in 1: one-cycle strobe, one coin inserted.
- `coin_value` in 2: coin code, 00=5, 01=10, 10=25, 11=100.
- `sel_valid` in 1: one-cycle strobe, purchase requested.
- `sel_product` in 2: product code, 00=apple, 01=banana, 10=carrot, 11=date.
- `cancel` in 1: one-cycle strobe, refund the whole balance.
- `apple`, `banana`, `carrot`, `date`, `error` in 1 each: manager response lines.
- `buy` out 1: request to manager, held high until response or timeout.
- `product` out 2: product code to manager, stable while `buy`=1.
- `credit` out 8: current balance; also the request credit while `buy`=1.
- `busy` out 1: high in REQ and WAIT.
- `coin_reject` out 1: one-cycle pulse, coin refused.
- `vend_ok` / `vend_fail` out 1 each: one-cycle purchase outcome pulses.
- `change_valid` out 1: one-cycle pulse; `change` out 8 is valid with it.

## Operation
- States are IDLE (balance 0), COLLECT (balance > 0), REQ, WAIT and PAYOUT.
- **Reset values:** state IDLE; `credit`=0; `buy`=0; `product`=00; `change`=0; all pulse outputs 0; `busy`=0.
- **Coin in IDLE/COLLECT:**
  - If balance + value ≤ 255, the balance adds the value and the state becomes COLLECT.
  - Otherwise the balance is unchanged and `coin_reject` pulses.
  - Coins in REQ, WAIT or PAYOUT are always rejected.
- **Selection:** honoured in COLLECT only. In IDLE it is ignored.
  - Local price check uses the package prices: apple 75, banana 20, carrot 30, date 40.
  - If balance < price: `vend_fail` pulses and the state stays COLLECT with the balance kept.
  - Otherwise `product` latches `sel_product` and the state goes to REQ.
- **Same-cycle priority:** `cancel` beats `coin_valid`, which beats `sel_valid`. Inputs that lose arbitration are dropped silently, with no reject pulse.
- **Cancel:** in COLLECT it goes to PAYOUT with change = balance. Ignored in other states.
- **REQ:** `buy`=1 for one cycle, then WAIT with `buy` still held.
- **WAIT:** the response lines are sampled every cycle.
  - Success: exactly one line is high and it matches `product`, with `error`=0. Then `vend_ok` pulses and change = balance − price.
  - `error`, a mismatched line, or more than one line high: `vend_fail` pulses and change = full balance.
  - No response within `RESP_TIMEOUT` WAIT cycles: treated as `vend_fail` with a full refund.
  - In every case the block moves to PAYOUT.
- **PAYOUT:** `change_valid` pulses for one cycle with `change`. The balance clears to 0 and the state returns to IDLE.
- Arithmetic is 8-bit unsigned. Subtraction cannot underflow because of the local price check.
- Reset asserted mid-operation returns every output immediately to its reset value. The balance is lost; there is no refund pulse.

## Timing
- Coin accepted at edge N: `credit` shows the new balance at N+1; `coin_reject` is high in cycle N+1.
- Selection at edge N: `buy` rises at N+1.
- Response sampled at edge M: `buy` falls and the `vend_ok`/`vend_fail` pulse appears at M+1; `change_valid` pulses at M+2.
- Timeout: with `buy` high at cycle N+1 and no response, `vend_fail` pulses at N+2+`RESP_TIMEOUT`.
- Response lines are ignored outside WAIT. They are also ignored in the REQ cycle itself.
- `product` and `credit` are held constant from the `buy` rise until `buy` falls.

## Structure
- Shared package `purchase_pkg` holds:
  - product code constants;
  - the price table (75/20/30/40);
  - coin value decode (5/10/25/100);
  - the state enum.
- Sub-module `coin_accumulator` holds the balance register, coin decode, overflow check and reject pulse, with load-clear control from the FSM.
- Top level holds the FSM, timeout counter, request drive and change calculation.

## Test plan
- **Apple purchase:**
  - Stimulus: coins 25,25,25 (credit=75); select apple; manager raises `apple` 2 cycles after `buy`.
  - Required: `vend_ok`, then `change_valid` with `change`=0; `credit` returns to 0.
- **Banana with change:** stimulus: coin 100, select banana, `banana` response. Required: `change`=80.
- **Insufficient credit:** stimulus: credit=20, select date. Required: `vend_fail`, no `buy` assertion, `credit` stays 20.
- **Error and mismatch:**
  - Credit=40, select carrot, manager raises `error`. Required: `vend_fail`, `change`=40.
  - Repeat with `date` raised instead of `carrot`. Required: same result.
- **Timeout:** stimulus: `RESP_TIMEOUT`=8, credit=30, select carrot, no response. Required: `vend_fail` exactly 9 cycles after `buy` rises, `change`=30.
- **Boundaries:**
  - Credit=200, coin 100: `coin_reject` pulses, credit stays 200.
  - `cancel` together with a coin: refund `change`=200.
  - Reset asserted during WAIT: `buy`=0 and `credit`=0 immediately.
